// File: rtl/riscv_div_writeback_if.sv
// Bundle of signals between the issue stage, the iterative divider, the
// register-file write arbiter and the divide writeback tracker.
// master: environment side (issue stage / divider / arbiter)
// slave : the tracker itself
`timescale 1ns/1ps
interface riscv_div_writeback_if;
  logic        issue_valid_i;
  logic [4:0]  issue_rd_idx_i;
  logic [31:0] issue_pc_i;
  logic        flush_i;
  logic        div_valid_i;
  logic [31:0] div_value_i;
  logic        rf_grant_i;
  logic        rf_req_o;
  logic [4:0]  rf_rd_idx_o;
  logic [31:0] rf_value_o;
  logic        stall_o;
  logic        busy_o;
  logic [4:0]  busy_rd_o;
  logic [31:0] pc_o;
  logic        error_o;
  logic        fwd_valid_o;
  logic [4:0]  fwd_rd_idx_o;
  logic [31:0] fwd_value_o;

  modport master (
    output issue_valid_i, issue_rd_idx_i, issue_pc_i, flush_i,
           div_valid_i, div_value_i, rf_grant_i,
    input  rf_req_o, rf_rd_idx_o, rf_value_o, stall_o, busy_o, busy_rd_o,
           pc_o, error_o, fwd_valid_o, fwd_rd_idx_o, fwd_value_o
  );

  modport slave (
    input  issue_valid_i, issue_rd_idx_i, issue_pc_i, flush_i,
           div_valid_i, div_value_i, rf_grant_i,
    output rf_req_o, rf_rd_idx_o, rf_value_o, stall_o, busy_o, busy_rd_o,
           pc_o, error_o, fwd_valid_o, fwd_rd_idx_o, fwd_value_o
  );
endinterface

// File: rtl/riscv_div_writeback.sv
// Divide completion / writeback tracker.
// Records rd/pc of an issued DIV/DIVU/REM/REMU, stalls further issue while
// the divider works, pairs the untagged divider result with the recorded rd
// and requests the shared register-file write port. Flushed divisions are
// drained and discarded; a watchdog flags a divider that never answers.
// Optional feature: define RISCV_DIV_WB_FWD_EN to drive the fwd_* bypass
// outputs during PEND; otherwise they are tied to 0.
//
// state | meaning
// IDLE  | nothing tracked, issue allowed
// WAIT  | division in flight, result will be written to rd
// PEND  | result captured, requesting register-file write port
// DRAIN | flushed division in flight, result will be discarded
`timescale 1ns/1ps
module riscv_div_writeback #(
  parameter int TIMEOUT_CYCLES = 40,
  parameter int CNT_W          = 6
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  riscv_div_writeback_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_PEND  = 2'd2,
    S_DRAIN = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_e            state_q, state_d;
  logic [4:0]        rd_q, rd_d;
  logic [31:0]       pc_q, pc_d;
  logic [31:0]       value_q, value_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              error_q, error_d;

  logic              timeout;
  logic [CNT_W-1:0]  cnt_inc;
  logic              pend;
  logic              busy;

  // >= rather than == so a flush landing on the last WAIT cycle still times out in DRAIN
  assign timeout = (cnt_q >= CNT_LAST);
  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

  // State and capture registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      rd_q    <= '0;
      pc_q    <= '0;
      value_q <= '0;
      cnt_q   <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rd_q    <= rd_d;
      pc_q    <= pc_d;
      value_q <= value_d;
      cnt_q   <= cnt_d;
      error_q <= error_d;
    end
  end

  // Next-state, capture and sticky error logic
  always_comb begin
    state_d = state_q;
    rd_d    = rd_q;
    pc_d    = pc_q;
    value_d = value_q;
    cnt_d   = cnt_q;
    error_d = error_q;

    if (bus.issue_valid_i && (state_q != S_IDLE)) begin
      error_d = 1'b1;
    end

    unique case (state_q)
      S_IDLE: begin
        if (bus.issue_valid_i) begin
          state_d = S_WAIT;
          rd_d    = bus.issue_rd_idx_i;
          pc_d    = bus.issue_pc_i;
          cnt_d   = '0;
        end
        if (bus.div_valid_i) begin
          error_d = 1'b1;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_inc;
        if (bus.flush_i && bus.div_valid_i) begin
          state_d = S_IDLE;
        end else if (bus.flush_i) begin
          state_d = S_DRAIN;
        end else if (bus.div_valid_i) begin
          value_d = bus.div_value_i;
          state_d = (rd_q == 5'd0) ? S_IDLE : S_PEND;
        end else if (timeout) begin
          error_d = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_PEND: begin
        if (bus.rf_grant_i) begin
          state_d = S_IDLE;
        end
      end
      S_DRAIN: begin
        cnt_d = cnt_inc;
        if (bus.div_valid_i) begin
          state_d = S_IDLE;
        end else if (timeout) begin
          error_d = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign pend = (state_q == S_PEND);
  assign busy = (state_q == S_WAIT) || pend;

  assign bus.rf_req_o    = pend;
  assign bus.rf_rd_idx_o = pend ? rd_q : 5'd0;
  assign bus.rf_value_o  = pend ? value_q : 32'd0;
  assign bus.stall_o     = (state_q != S_IDLE);
  assign bus.busy_o      = busy;
  assign bus.busy_rd_o   = busy ? rd_q : 5'd0;
  assign bus.pc_o        = pc_q;
  assign bus.error_o     = error_q;

`ifdef RISCV_DIV_WB_FWD_EN
  assign bus.fwd_valid_o  = pend;
  assign bus.fwd_rd_idx_o = rd_q;
  assign bus.fwd_value_o  = value_q;
`else
  assign bus.fwd_valid_o  = 1'b0;
  assign bus.fwd_rd_idx_o = 5'd0;
  assign bus.fwd_value_o  = 32'd0;
`endif

endmodule

// File: tb/tb_riscv_div_writeback.sv
// Directed bench for riscv_div_writeback. Inputs change 1 ns after the
// rising edge, outputs are sampled at the same point.
`timescale 1ns/1ps
module tb_riscv_div_writeback;

  logic clk_i;
  logic rst_i;
  int   n_vec;
  int   n_err;

  riscv_div_writeback_if bus_if ();

  riscv_div_writeback #(.TIMEOUT_CYCLES(40), .CNT_W(6)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus_if)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "bench watchdog");
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic clear_inputs();
    bus_if.issue_valid_i  = 1'b0;
    bus_if.issue_rd_idx_i = 5'd0;
    bus_if.issue_pc_i     = 32'd0;
    bus_if.flush_i        = 1'b0;
    bus_if.div_valid_i    = 1'b0;
    bus_if.div_value_i    = 32'd0;
    bus_if.rf_grant_i     = 1'b0;
  endtask

  task automatic apply_reset();
    clear_inputs();
    rst_i = 1'b1;
    step(1);
    rst_i = 1'b0;
    step(1);
  endtask

  // Leaves the bench in the first WAIT cycle (cycle 1 after issue in cycle 0)
  task automatic do_issue(input logic [4:0] rd, input logic [31:0] pc);
    bus_if.issue_valid_i  = 1'b1;
    bus_if.issue_rd_idx_i = rd;
    bus_if.issue_pc_i     = pc;
    step(1);
    bus_if.issue_valid_i  = 1'b0;
    bus_if.issue_rd_idx_i = 5'd0;
    bus_if.issue_pc_i     = 32'd0;
  endtask

  task automatic do_result(input logic [31:0] value);
    bus_if.div_valid_i = 1'b1;
    bus_if.div_value_i = value;
    step(1);
    bus_if.div_valid_i = 1'b0;
    bus_if.div_value_i = 32'd0;
  endtask

  function automatic logic [115:0] all_outs();
    return {bus_if.rf_req_o, bus_if.rf_rd_idx_o, bus_if.rf_value_o,
            bus_if.stall_o, bus_if.busy_o, bus_if.busy_rd_o, bus_if.pc_o,
            bus_if.error_o, bus_if.fwd_valid_o, bus_if.fwd_rd_idx_o,
            bus_if.fwd_value_o};
  endfunction

  task automatic test_reset();
    clear_inputs();
    rst_i = 1'b1;
    step(2);
    n_vec++;
    if (all_outs() !== 116'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got %h expected 0", all_outs());
    end
    rst_i = 1'b0;
    step(1);
    n_vec++;
    if (all_outs() !== 116'd0) begin
      n_err++;
      $display("FAIL reset_release: got %h expected 0", all_outs());
    end
  endtask

  task automatic test_basic();
    do_issue(5'd5, 32'h100);
    n_vec++;
    if ({bus_if.stall_o, bus_if.busy_o, bus_if.busy_rd_o, bus_if.pc_o, bus_if.rf_req_o}
        !== {1'b1, 1'b1, 5'd5, 32'h100, 1'b0}) begin
      n_err++;
      $display("FAIL basic_wait: got stall=%b busy=%b busy_rd=%0d pc=%h req=%b expected 1 1 5 00000100 0",
               bus_if.stall_o, bus_if.busy_o, bus_if.busy_rd_o, bus_if.pc_o, bus_if.rf_req_o);
    end
    step(33);
    n_vec++;
    if ({bus_if.stall_o, bus_if.rf_req_o} !== 2'b10) begin
      n_err++;
      $display("FAIL basic_cycle34: got stall=%b req=%b expected 1 0", bus_if.stall_o, bus_if.rf_req_o);
    end
    do_result(32'h7);
    n_vec++;
    if ({bus_if.rf_req_o, bus_if.rf_rd_idx_o, bus_if.rf_value_o, bus_if.stall_o, bus_if.busy_o}
        !== {1'b1, 5'd5, 32'h7, 1'b1, 1'b1}) begin
      n_err++;
      $display("FAIL basic_req: got req=%b rd=%0d val=%h stall=%b busy=%b expected 1 5 00000007 1 1",
               bus_if.rf_req_o, bus_if.rf_rd_idx_o, bus_if.rf_value_o, bus_if.stall_o, bus_if.busy_o);
    end
    bus_if.rf_grant_i = 1'b1;
    step(1);
    bus_if.rf_grant_i = 1'b0;
    n_vec++;
    if ({bus_if.rf_req_o, bus_if.rf_rd_idx_o, bus_if.rf_value_o, bus_if.stall_o,
         bus_if.busy_o, bus_if.busy_rd_o, bus_if.error_o} !== 46'd0) begin
      n_err++;
      $display("FAIL basic_done: got req=%b rd=%0d val=%h stall=%b busy=%b busy_rd=%0d err=%b expected all 0",
               bus_if.rf_req_o, bus_if.rf_rd_idx_o, bus_if.rf_value_o, bus_if.stall_o,
               bus_if.busy_o, bus_if.busy_rd_o, bus_if.error_o);
    end
  endtask

  task automatic test_grant_delay();
    logic [37:0] exp_fwd;
    do_issue(5'd5, 32'h100);
    step(33);
    do_result(32'h7);
`ifdef RISCV_DIV_WB_FWD_EN
    exp_fwd = {1'b1, 5'd5, 32'h7};
`else
    exp_fwd = 38'd0;
`endif
    for (int i = 0; i < 4; i++) begin
      bus_if.rf_grant_i = (i == 3);
      n_vec++;
      if ({bus_if.rf_req_o, bus_if.rf_rd_idx_o, bus_if.rf_value_o, bus_if.stall_o}
          !== {1'b1, 5'd5, 32'h7, 1'b1}) begin
        n_err++;
        $display("FAIL grant_hold[%0d]: got req=%b rd=%0d val=%h stall=%b expected 1 5 00000007 1",
                 i, bus_if.rf_req_o, bus_if.rf_rd_idx_o, bus_if.rf_value_o, bus_if.stall_o);
      end
      n_vec++;
      if ({bus_if.fwd_valid_o, bus_if.fwd_rd_idx_o, bus_if.fwd_value_o} !== exp_fwd) begin
        n_err++;
        $display("FAIL fwd_hold[%0d]: got %b %0d %h expected %h", i, bus_if.fwd_valid_o,
                 bus_if.fwd_rd_idx_o, bus_if.fwd_value_o, exp_fwd);
      end
      step(1);
    end
    bus_if.rf_grant_i = 1'b0;
    n_vec++;
    if ({bus_if.rf_req_o, bus_if.stall_o, bus_if.fwd_valid_o} !== 3'b000) begin
      n_err++;
      $display("FAIL grant_release: got req=%b stall=%b fwd=%b expected 0 0 0",
               bus_if.rf_req_o, bus_if.stall_o, bus_if.fwd_valid_o);
    end
  endtask

  task automatic test_rd_zero();
    do_issue(5'd0, 32'h200);
    step(33);
    n_vec++;
    if ({bus_if.busy_o, bus_if.busy_rd_o, bus_if.stall_o} !== {1'b1, 5'd0, 1'b1}) begin
      n_err++;
      $display("FAIL rd0_wait: got busy=%b busy_rd=%0d stall=%b expected 1 0 1",
               bus_if.busy_o, bus_if.busy_rd_o, bus_if.stall_o);
    end
    do_result(32'h55);
    n_vec++;
    if ({bus_if.rf_req_o, bus_if.stall_o, bus_if.busy_o, bus_if.error_o} !== 4'b0000) begin
      n_err++;
      $display("FAIL rd0_done: got req=%b stall=%b busy=%b err=%b expected 0 0 0 0",
               bus_if.rf_req_o, bus_if.stall_o, bus_if.busy_o, bus_if.error_o);
    end
  endtask

  task automatic test_flush();
    logic bad;
    do_issue(5'd9, 32'h300);
    n_vec++;
    if (bus_if.busy_rd_o !== 5'd9) begin
      n_err++;
      $display("FAIL flush_busy_rd: got %0d expected 9", bus_if.busy_rd_o);
    end
    step(9);
    bus_if.flush_i = 1'b1;
    step(1);
    bus_if.flush_i = 1'b0;
    n_vec++;
    if ({bus_if.stall_o, bus_if.busy_o, bus_if.busy_rd_o} !== {1'b1, 1'b0, 5'd0}) begin
      n_err++;
      $display("FAIL flush_drain: got stall=%b busy=%b busy_rd=%0d expected 1 0 0",
               bus_if.stall_o, bus_if.busy_o, bus_if.busy_rd_o);
    end
    bad = 1'b0;
    for (int c = 11; c <= 34; c++) begin
      if (bus_if.stall_o !== 1'b1 || bus_if.rf_req_o !== 1'b0) bad = 1'b1;
      if (c < 34) step(1);
    end
    n_vec++;
    if (bad !== 1'b0) begin
      n_err++;
      $display("FAIL flush_stall_hold: got a cycle with stall low or req high, expected stall 1 req 0 through cycle 34");
    end
    do_result(32'hDEAD);
    n_vec++;
    if ({bus_if.stall_o, bus_if.rf_req_o, bus_if.error_o} !== 3'b000) begin
      n_err++;
      $display("FAIL flush_done: got stall=%b req=%b err=%b expected 0 0 0",
               bus_if.stall_o, bus_if.rf_req_o, bus_if.error_o);
    end
  endtask

  task automatic test_late_result();
    do_issue(5'd7, 32'h400);
    step(39);
    n_vec++;
    if ({bus_if.stall_o, bus_if.error_o} !== 2'b10) begin
      n_err++;
      $display("FAIL late_cycle40: got stall=%b err=%b expected 1 0", bus_if.stall_o, bus_if.error_o);
    end
    do_result(32'hABCD);
    n_vec++;
    if ({bus_if.rf_req_o, bus_if.rf_rd_idx_o, bus_if.rf_value_o, bus_if.error_o}
        !== {1'b1, 5'd7, 32'hABCD, 1'b0}) begin
      n_err++;
      $display("FAIL late_req: got req=%b rd=%0d val=%h err=%b expected 1 7 0000abcd 0",
               bus_if.rf_req_o, bus_if.rf_rd_idx_o, bus_if.rf_value_o, bus_if.error_o);
    end
    bus_if.rf_grant_i = 1'b1;
    step(1);
    bus_if.rf_grant_i = 1'b0;
  endtask

  task automatic test_back_to_back();
    do_issue(5'd5, 32'h100);
    step(33);
    do_result(32'h11);
    bus_if.rf_grant_i = 1'b1;
    step(1);
    bus_if.rf_grant_i = 1'b0;
    n_vec++;
    if (bus_if.stall_o !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_stall_low: got %b expected 0", bus_if.stall_o);
    end
    do_issue(5'd6, 32'h104);
    n_vec++;
    if ({bus_if.stall_o, bus_if.busy_rd_o, bus_if.pc_o, bus_if.error_o}
        !== {1'b1, 5'd6, 32'h104, 1'b0}) begin
      n_err++;
      $display("FAIL b2b_second_issue: got stall=%b busy_rd=%0d pc=%h err=%b expected 1 6 00000104 0",
               bus_if.stall_o, bus_if.busy_rd_o, bus_if.pc_o, bus_if.error_o);
    end
    step(33);
    do_result(32'h22);
    n_vec++;
    if ({bus_if.rf_req_o, bus_if.rf_rd_idx_o, bus_if.rf_value_o} !== {1'b1, 5'd6, 32'h22}) begin
      n_err++;
      $display("FAIL b2b_second_req: got req=%b rd=%0d val=%h expected 1 6 00000022",
               bus_if.rf_req_o, bus_if.rf_rd_idx_o, bus_if.rf_value_o);
    end
    bus_if.rf_grant_i = 1'b1;
    step(1);
    bus_if.rf_grant_i = 1'b0;
  endtask

  task automatic test_issue_while_busy();
    do_issue(5'd4, 32'h600);
    do_issue(5'd8, 32'h700);
    n_vec++;
    if ({bus_if.error_o, bus_if.busy_rd_o, bus_if.pc_o} !== {1'b1, 5'd4, 32'h600}) begin
      n_err++;
      $display("FAIL busy_issue: got err=%b busy_rd=%0d pc=%h expected 1 4 00000600",
               bus_if.error_o, bus_if.busy_rd_o, bus_if.pc_o);
    end
    apply_reset();
  endtask

  task automatic test_timeout();
    do_issue(5'd3, 32'h500);
    step(39);
    n_vec++;
    if ({bus_if.stall_o, bus_if.error_o} !== 2'b10) begin
      n_err++;
      $display("FAIL timeout_before: got stall=%b err=%b expected 1 0", bus_if.stall_o, bus_if.error_o);
    end
    step(1);
    n_vec++;
    if ({bus_if.stall_o, bus_if.busy_o, bus_if.error_o} !== 3'b001) begin
      n_err++;
      $display("FAIL timeout_fire: got stall=%b busy=%b err=%b expected 0 0 1",
               bus_if.stall_o, bus_if.busy_o, bus_if.error_o);
    end
    do_result(32'h99);
    n_vec++;
    if ({bus_if.error_o, bus_if.stall_o, bus_if.rf_req_o} !== 3'b100) begin
      n_err++;
      $display("FAIL idle_result: got err=%b stall=%b req=%b expected 1 0 0",
               bus_if.error_o, bus_if.stall_o, bus_if.rf_req_o);
    end
    apply_reset();
    n_vec++;
    if (bus_if.error_o !== 1'b0) begin
      n_err++;
      $display("FAIL error_clear: got %b expected 0", bus_if.error_o);
    end
  endtask

  task automatic test_reset_mid_wait();
    do_issue(5'd12, 32'h800);
    step(5);
    rst_i = 1'b1;
    #1;
    n_vec++;
    if (all_outs() !== 116'd0) begin
      n_err++;
      $display("FAIL reset_mid_wait: got %h expected 0", all_outs());
    end
    step(1);
    rst_i = 1'b0;
    step(1);
    n_vec++;
    if (all_outs() !== 116'd0) begin
      n_err++;
      $display("FAIL reset_mid_wait_after: got %h expected 0", all_outs());
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_i = 1'b1;
    clear_inputs();
    test_reset();
    test_basic();
    test_grant_delay();
    test_rd_zero();
    test_flush();
    test_late_result();
    test_back_to_back();
    test_issue_while_busy();
    test_timeout();
    test_reset_mid_wait();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
